// File: rtl/chrom_eval_pkg.sv
// Shared types and constants for the chromosome evaluation controller.
// Imported by the controller top and its per-lane accumulators.
package chrom_eval_pkg;

  localparam int ADDR_W = 15;
  localparam int LANES  = 8;
  localparam int MAX_N  = 32768;
  localparam int CNT_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  function automatic logic [2:0] popcnt4(
    input logic [3:0] v
  );
    return {2'b0, v[0]} + {2'b0, v[1]} +
           {2'b0, v[2]} + {2'b0, v[3]};
  endfunction

endpackage

// File: rtl/chrom_err_acc.sv
// One 4-bit lane: masked mismatch popcount feeding
// a 32-bit running error sum with synchronous clear.
module chrom_err_acc
  import chrom_eval_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [3:0]  out_i,
  input  logic [3:0]  exp_i,
  input  logic [3:0]  mask_i,
  output logic [31:0] sum_o
);

  logic [31:0] sum_q;
  logic [31:0] sum_d;
  logic [2:0]  cnt;

  assign cnt = popcnt4((out_i ^ exp_i) & mask_i);

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (en_i) begin
      sum_d = sum_q + {29'd0, cnt};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/chrom_eval_ctrl.sv
// Streams N samples through the circuit under evaluation and
// accumulates per-lane masked mismatch counts against expected RAM.
module chrom_eval_ctrl
  import chrom_eval_pkg::*;
#(
  parameter int EVAL_LAT = 1
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        start_processing_chrom,
  input  logic        done_processing_feedback,
  input  logic [31:0] sequences_to_process,
  input  logic [31:0] valid_output_0,
  output logic        ready_to_process,
  output logic        done_processing_chrom,
  output logic [31:0] error_sum_0,
  output logic [31:0] error_sum_1,
  output logic [31:0] error_sum_2,
  output logic [31:0] error_sum_3,
  output logic [31:0] error_sum_4,
  output logic [31:0] error_sum_5,
  output logic [31:0] error_sum_6,
  output logic [31:0] error_sum_7,
  output logic [14:0] mem_s2_address,
  output logic        mem_s2_chipselect,
  output logic        mem_s2_clken,
  output logic        mem_s2_write,
  output logic [31:0] mem_s2_writedata,
  output logic [3:0]  mem_s2_byteenable,
  input  logic [31:0] mem_s2_readdata,
  output logic [14:0] correct_mem_s2_address,
  output logic        correct_mem_s2_chipselect,
  output logic        correct_mem_s2_clken,
  output logic        correct_mem_s2_write,
  output logic [31:0] correct_mem_s2_writedata,
  output logic [3:0]  correct_mem_s2_byteenable,
  input  logic [31:0] correct_mem_s2_readdata,
  output logic [31:0] circ_in,
  input  logic [31:0] circ_out
);

  state_e            state_q;
  logic [CNT_W-1:0]  n_q;
  logic [CNT_W-1:0]  n_d;
  logic [31:0]       mask_q;
  logic [ADDR_W-1:0] addr_q;
  logic              cs_q;
  logic              ready_q;
  logic              done_q;
  logic [EVAL_LAT:0] vld_q;
  logic [31:0]       exp_q [EVAL_LAT];
  logic [31:0]       circ_q;
  logic              clr;
  logic              last_addr;
  logic              acc_en;
  logic [31:0]       exp_cur;
  logic [31:0]       sum_w [LANES];

  assign n_d = (sequences_to_process > 32'(MAX_N))
             ? CNT_W'(MAX_N)
             : sequences_to_process[CNT_W-1:0];

  assign clr = (state_q == ST_IDLE) &&
               start_processing_chrom;

  assign last_addr = ({1'b0, addr_q} == (n_q - 1'b1));

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      mask_q  <= '0;
      addr_q  <= '0;
      cs_q    <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_processing_chrom) begin
            n_q     <= n_d;
            mask_q  <= valid_output_0;
            addr_q  <= '0;
            ready_q <= 1'b0;
            if (n_d == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              cs_q    <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (last_addr) begin
            state_q <= ST_DRAIN;
            cs_q    <= 1'b0;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
        end
        // Last accumulation has landed once the pipe is empty.
        ST_DRAIN: begin
          if (vld_q == '0) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (done_processing_feedback &&
              !start_processing_chrom) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      vld_q  <= '0;
      circ_q <= '0;
      for (int k = 0; k < EVAL_LAT; k++) begin
        exp_q[k] <= '0;
      end
    end else begin
      vld_q    <= {vld_q[EVAL_LAT-1:0], cs_q};
      exp_q[0] <= correct_mem_s2_readdata;
      for (int k = 1; k < EVAL_LAT; k++) begin
        exp_q[k] <= exp_q[k-1];
      end
      if (vld_q[0]) begin
        circ_q <= mem_s2_readdata;
      end
    end
  end

  assign acc_en  = vld_q[EVAL_LAT];
  assign exp_cur = exp_q[EVAL_LAT-1];

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    chrom_err_acc u_acc (
      .clk_i  (clk_clk),
      .rst_ni (reset_reset_n),
      .clr_i  (clr),
      .en_i   (acc_en),
      .out_i  (circ_out[4*k +: 4]),
      .exp_i  (exp_cur[4*k +: 4]),
      .mask_i (mask_q[4*k +: 4]),
      .sum_o  (sum_w[k])
    );
  end

  assign error_sum_0 = sum_w[0];
  assign error_sum_1 = sum_w[1];
  assign error_sum_2 = sum_w[2];
  assign error_sum_3 = sum_w[3];
  assign error_sum_4 = sum_w[4];
  assign error_sum_5 = sum_w[5];
  assign error_sum_6 = sum_w[6];
  assign error_sum_7 = sum_w[7];

  assign ready_to_process      = ready_q;
  assign done_processing_chrom = done_q;
  assign circ_in               = circ_q;

  assign mem_s2_address    = addr_q;
  assign mem_s2_chipselect = cs_q;
  assign mem_s2_clken      = cs_q;
  assign mem_s2_write      = 1'b0;
  assign mem_s2_writedata  = '0;
  assign mem_s2_byteenable = 4'hF;

  assign correct_mem_s2_address    = addr_q;
  assign correct_mem_s2_chipselect = cs_q;
  assign correct_mem_s2_clken      = cs_q;
  assign correct_mem_s2_write      = 1'b0;
  assign correct_mem_s2_writedata  = '0;
  assign correct_mem_s2_byteenable = 4'hF;

endmodule
